// File: rtl/code_entry.sv
// Keypad-style code entry: synchronizes and debounces an ENTER button, samples digit switches on
// each press, and assembles CODE_LEN digits into one code with an inter-digit timeout.
module code_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CODE_LEN        = 6,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [3:0] sw,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic [2:0] digit_idx,
  output logic       digit_reject,
  output logic       seq_done,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StEmpty, StCollect, StComplete} state_e;

  logic           key_s1_q, key_s2_q;
  logic [3:0]     sw_s1_q, sw_s2_q;
  logic           key_filt_q;
  logic [DbW-1:0] db_cnt_q;
  logic [DbW-1:0] rel_cnt_q;
  logic           armed_q;
  state_e         state_q;
  logic [3:0]     count_q;
  logic [TW-1:0]  tcnt_q;

  logic db_hit, press, sw_ok, last_digit;

  assign db_hit     = (key_s2_q != key_filt_q) && (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1));
  // A press only counts once the button has been seen released after reset.
  assign press      = db_hit && key_filt_q && armed_q;
  assign sw_ok      = (sw_s2_q <= 4'd9);
  assign last_digit = (count_q == 4'(CODE_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      sw_s1_q    <= 4'd0;
      sw_s2_q    <= 4'd0;
      key_filt_q <= 1'b1;
      db_cnt_q   <= '0;
      rel_cnt_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      if (key_s2_q == key_filt_q) begin
        db_cnt_q <= '0;
      end else if (db_hit) begin
        key_filt_q <= key_s2_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
      if (!armed_q) begin
        if (!key_s2_q) begin
          rel_cnt_q <= '0;
        end else if (rel_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          armed_q <= 1'b1;
        end else begin
          rel_cnt_q <= rel_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      count_q      <= 4'd0;
      tcnt_q       <= '0;
      digit        <= 4'd0;
      digit_idx    <= 3'd0;
      digit_valid  <= 1'b0;
      digit_reject <= 1'b0;
      seq_done     <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      digit_valid  <= 1'b0;
      digit_reject <= 1'b0;
      seq_done     <= 1'b0;
      timeout      <= 1'b0;
      case (state_q)
        StEmpty, StCollect: begin
          if (press && sw_ok) begin
            digit       <= sw_s2_q;
            digit_idx   <= 3'(count_q);
            digit_valid <= 1'b1;
            count_q     <= count_q + 4'd1;
            tcnt_q      <= '0;
            if (last_digit) begin
              state_q <= StComplete;
              busy    <= 1'b0;
            end else begin
              state_q <= StCollect;
              busy    <= 1'b1;
            end
          end else if (press) begin
            digit_reject <= 1'b1;
          end else if (state_q == StCollect) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
              timeout <= 1'b1;
              count_q <= 4'd0;
              tcnt_q  <= '0;
              state_q <= StEmpty;
              busy    <= 1'b0;
            end else begin
              tcnt_q <= tcnt_q + 1'b1;
            end
          end
        end
        StComplete: begin
          seq_done <= 1'b1;
          count_q  <= 4'd0;
          tcnt_q   <= '0;
          state_q  <= StEmpty;
          busy     <= 1'b0;
        end
        default: begin
          state_q <= StEmpty;
          count_q <= 4'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry: clean entry, bounce, reject, timeout and reset-with-key-held.
module tb_code_entry;

  localparam int unsigned TO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [3:0] sw = 4'd0;
  logic [3:0] digit;
  logic       digit_valid;
  logic [2:0] digit_idx;
  logic       digit_reject;
  logic       seq_done;
  logic       timeout;
  logic       busy;

  code_entry #(
    .DEBOUNCE_CYCLES(4),
    .CODE_LEN       (6),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .sw          (sw),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_idx   (digit_idx),
    .digit_reject(digit_reject),
    .seq_done    (seq_done),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts every strobe and remembers the last accepted digit.
  int n_dv = 0, n_rej = 0, n_done = 0, n_to = 0, n_excl = 0, cyc = 0;
  int dv_cyc = 0, done_cyc = 0;
  logic [3:0] last_digit = 4'd0;
  logic [2:0] last_idx = 3'd0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (digit_valid === 1'b1) begin
      n_dv       <= n_dv + 1;
      dv_cyc     <= cyc;
      last_digit <= digit;
      last_idx   <= digit_idx;
    end
    if (digit_reject === 1'b1) n_rej <= n_rej + 1;
    if (seq_done === 1'b1) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (timeout === 1'b1) n_to <= n_to + 1;
    if (int'(digit_valid === 1'b1) + int'(digit_reject === 1'b1) + int'(seq_done === 1'b1)
        + int'(timeout === 1'b1) > 1) n_excl <= n_excl + 1;
  end

  int vecs = 0, errs = 0;
  int b_dv, b_rej, b_done, b_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic snap();
    b_dv   = n_dv;
    b_rej  = n_rej;
    b_done = n_done;
    b_to   = n_to;
  endtask

  task automatic press(input logic [3:0] v);
    sw = v;
    tick(4);
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
  endtask

  logic [3:0] code [6];

  initial begin
    code = '{4'd6, 4'd6, 4'd5, 4'd2, 4'd3, 4'd9};

    // Reset state
    tick(3);
    check("rst_digit", digit, 0);
    check("rst_idx", digit_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {digit_valid, digit_reject, seq_done, timeout}, 0);
    rst_n = 1'b1;
    tick(10);

    // Clean six-digit entry
    snap();
    for (int i = 0; i < 6; i++) begin
      press(code[i]);
      check("clean_digit", last_digit, code[i]);
      check("clean_idx", last_idx, i);
    end
    check("clean_dv_count", n_dv - b_dv, 6);
    check("clean_done_count", n_done - b_done, 1);
    check("clean_done_latency", done_cyc - dv_cyc, 1);
    check("clean_busy_after", busy, 0);

    // Bouncing press yields exactly one digit
    snap();
    sw = 4'd4;
    tick(4);
    repeat (3) begin
      key_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      tick(2);
    end
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
    check("bounce_dv_count", n_dv - b_dv, 1);
    check("bounce_digit", last_digit, 4);
    check("bounce_idx", last_idx, 0);

    // Second digit, then a rejected value, then the third digit
    press(4'd1);
    check("rej_pre_idx", last_idx, 1);
    snap();
    press(4'd12);
    check("rej_count", n_rej - b_rej, 1);
    check("rej_no_dv", n_dv - b_dv, 0);
    check("rej_busy", busy, 1);
    check("rej_digit_held", digit, 1);
    press(4'd7);
    check("rej_next_idx", last_idx, 2);
    check("rej_next_digit", last_digit, 7);

    // Timeout with three digits held
    snap();
    tick(TO - 40);
    check("to_not_early", n_to - b_to, 0);
    check("to_busy_before", busy, 1);
    tick(80);
    check("to_count", n_to - b_to, 1);
    check("to_busy_after", busy, 0);
    press(4'd8);
    check("to_next_idx", last_idx, 0);
    check("to_next_digit", last_digit, 8);

    // Reset after four digits with the key held low across reset release
    press(4'd0);
    press(4'd3);
    press(4'd5);
    check("pre_rst_idx", last_idx, 3);
    snap();
    rst_n = 1'b0;
    key_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(15);
    check("rst_mid_no_dv", n_dv - b_dv, 0);
    check("rst_mid_no_other", (n_rej - b_rej) + (n_done - b_done) + (n_to - b_to), 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_idx", digit_idx, 0);
    key_n = 1'b1;
    tick(10);
    press(4'd5);
    check("rst_next_dv", n_dv - b_dv, 1);
    check("rst_next_idx", last_idx, 0);
    check("rst_next_digit", last_digit, 5);

    check("strobes_exclusive", n_excl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/code_entry.md
CODE_ENTRY -- requirements
Module: code_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required to accept a key level change.
REQ-002 Parameter CODE_LEN, default 6: number of accepted digits that form one complete code entry.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between accepted digits before the partial entry is abandoned.
REQ-004 clk  input  1  system clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 key_n  input  1  raw ENTER pushbutton, active-low, asynchronous to clk, bouncing.
REQ-007 sw  input  4  raw digit switches, asynchronous to clk.
REQ-008 digit  output  4  value of the last accepted digit; held until the next accept.
REQ-009 digit_valid  output  1  one-cycle strobe; digit and digit_idx are valid in this cycle.
REQ-010 digit_idx  output  3  position of the accepted digit, 0 to CODE_LEN-1.
REQ-011 digit_reject  output  1  one-cycle strobe; press seen with sw value 10-15.
REQ-012 seq_done  output  1  one-cycle strobe; CODE_LEN digits collected.
REQ-013 timeout  output  1  one-cycle strobe; partial entry abandoned.
REQ-014 busy  output  1  high while 1 to CODE_LEN-1 digits are held.

Function
REQ-015 key_n and sw SHALL each pass through a two-flop synchronizer before any use.
REQ-016 Debounce: the filtered key level SHALL change only after the synchronized key_n holds the new level for DEBOUNCE_CYCLES consecutive cycles; any opposite sample restarts the count.
REQ-017 A press event SHALL be the filtered level going high-to-low; exactly one press event per physical press, regardless of bounce.
REQ-018 On a press event, the synchronized sw value SHALL be sampled in the same cycle; digit_valid or digit_reject SHALL assert in the following cycle (1-cycle latency from press event).
REQ-019 sw 0-9 SHALL be accepted; sw 10-15 SHALL pulse digit_reject and SHALL leave digit, digit_idx, count and the timeout counter unchanged.
REQ-020 Entry FSM states: EMPTY (count 0), COLLECT (0 < count < CODE_LEN), COMPLETE (one cycle).
REQ-021 EMPTY: an accepted digit gives digit_idx=0, count=1, and moves to COLLECT (or COMPLETE if CODE_LEN=1).
REQ-022 COLLECT: an accepted digit gives digit_idx=count and count+1; the transition to COMPLETE SHALL occur when count reaches CODE_LEN.
REQ-023 COMPLETE: seq_done SHALL be high for exactly that one cycle, coincident with the following cycle after the final digit_valid; count SHALL clear; next state EMPTY; press events in COMPLETE SHALL be ignored.
REQ-024 The timeout counter SHALL clear on every accepted digit and increment each cycle in COLLECT.
REQ-025 On reaching TIMEOUT_CYCLES in COLLECT, timeout SHALL pulse for one cycle, count SHALL clear, and the state SHALL return to EMPTY.
REQ-026 If a press is accepted in the same cycle the timeout would fire, the accept SHALL win and the timeout counter SHALL clear.
REQ-027 busy SHALL be high exactly in COLLECT.
REQ-028 All strobes SHALL be registered outputs and mutually exclusive in any cycle.

Reset
REQ-029 While rst_n=0 at a clock edge: state EMPTY, count 0, timeout counter 0, filtered key released (high), synchronizers set to key_n=1 and sw=0.
REQ-030 Reset outputs: digit=0, digit_idx=0, and digit_valid, digit_reject, seq_done, timeout and busy all 0.
REQ-031 Reset asserted mid-entry SHALL discard the partial code with no strobe; a key held low through reset release SHALL NOT generate a press until it is released and pressed again.

Verification
REQ-032 Clean entry: press with sw = 6,6,5,2,3,9, each press held 10 cycles -> digit_valid x6 with idx 0-5, then seq_done 1 cycle after the last digit_valid, busy low afterwards.
REQ-033 Bounce: key_n toggles 3 times with 2-cycle gaps, then holds low for 10 cycles, sw=4 -> exactly one digit_valid with digit=4.
REQ-034 Reject: 2 digits accepted, then press with sw=12 -> digit_reject only, busy stays 1; the next press with sw=7 -> digit_idx=2.
REQ-035 Timeout: 3 digits accepted, then idle for TIMEOUT_CYCLES -> timeout pulse, busy 0; the next accepted digit has idx 0.
REQ-036 Reset mid-entry after 4 digits, with the key held low across reset release -> no strobes; the following release and press gives idx 0.
